// File: rtl/life_pkg.sv
// Shared types, sizes and helpers for the Game of Life generation controller.
package life_pkg;

    localparam int GRID_W    = 16;
    localparam int GRID_H    = 16;
    localparam int ROW_IDX_W = 4;
    localparam int CNT_W     = 9;

    typedef logic [GRID_H-1:0][GRID_W-1:0] environment_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPUTE = 2'd1,
        COMMIT  = 2'd2,
        WAIT    = 2'd3
    } ctrl_state_t;

    function automatic logic [4:0] popcount16(input logic [GRID_W-1:0] v);
        logic [4:0] c;
        c = '0;
        for (int i = 0; i < GRID_W; i++) begin
            c = c + {4'b0000, v[i]};
        end
        return c;
    endfunction

endpackage

// File: rtl/life_row_eval.sv
// Combinational next-state of one grid row from its two vertical neighbours.
// Columns wrap 0<->15 here; the caller supplies the vertically wrapped rows.
module life_row_eval
    import life_pkg::*;
(
    input  logic [GRID_W-1:0] row_above,
    input  logic [GRID_W-1:0] row_centre,
    input  logic [GRID_W-1:0] row_below,
    output logic [GRID_W-1:0] next_row,
    output logic [4:0]        births,
    output logic [4:0]        deaths
);

    logic [GRID_W-1:0] birth_vec;
    logic [GRID_W-1:0] death_vec;

    genvar gi;
    generate
        for (gi = 0; gi < GRID_W; gi++) begin : g_cell
            localparam int L = (gi + GRID_W - 1) % GRID_W;
            localparam int R = (gi + 1) % GRID_W;
            logic [3:0] nbr;

            assign nbr = {3'b000, row_above[L]}  + {3'b000, row_above[gi]}  + {3'b000, row_above[R]}
                       + {3'b000, row_centre[L]}                            + {3'b000, row_centre[R]}
                       + {3'b000, row_below[L]}  + {3'b000, row_below[gi]}  + {3'b000, row_below[R]};

            assign next_row[gi]  = (nbr == 4'd3) | (row_centre[gi] & (nbr == 4'd2));
            assign birth_vec[gi] = ~row_centre[gi] &  next_row[gi];
            assign death_vec[gi] =  row_centre[gi] & ~next_row[gi];
        end
    endgenerate

    assign births = popcount16(birth_vec);
    assign deaths = popcount16(death_vec);

endmodule

// File: rtl/life_gen_controller.sv
// 16x16 toroidal Game of Life: row-serial evaluation into a shadow buffer,
// single-cycle commit, seed loading, run/step control and generation statistics.
module life_gen_controller
    import life_pkg::*;
#(
    parameter int GEN_W     = 16,
    parameter int TICK_DIV  = 0,
    parameter int AUTO_HALT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_valid,
    output logic              load_ready,
    input  logic [3:0]        load_row,
    input  logic [15:0]       load_data,
    input  logic              cmd_run,
    input  logic              cmd_stop,
    input  logic              cmd_step,
    input  logic              cmd_clear,
    input  logic [3:0]        rd_row,
    output logic [15:0]       rd_data,
    output logic              busy,
    output logic              gen_done,
    output logic [GEN_W-1:0]  generation,
    output logic [8:0]        birth_cnt,
    output logic [8:0]        death_cnt,
    output logic [8:0]        population,
    output logic              stable
);

    localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    ctrl_state_t          state_reg, state_next;
    environment_t         grid_reg, shadow_reg;
    logic [ROW_IDX_W-1:0] row_cnt_reg, row_up, row_dn;
    logic [TICK_W-1:0]    tick_cnt_reg;
    logic                 run_mode_reg, stop_pending_reg;
    logic [CNT_W-1:0]     birth_acc_reg, death_acc_reg, pop_acc_reg;
    logic [CNT_W-1:0]     birth_cnt_reg, death_cnt_reg, population_reg;
    logic [GEN_W-1:0]     generation_reg;
    logic                 stable_reg, gen_done_reg;

    logic                 load_fire, same_c, halt_c, tick_last;
    logic [CNT_W-1:0]     pop_load;
    logic [GRID_W-1:0]    eval_row;
    logic [4:0]           eval_births, eval_deaths;

    // Vertical wrap falls out of 4-bit modular row arithmetic.
    assign row_up = row_cnt_reg - ROW_IDX_W'(1);
    assign row_dn = row_cnt_reg + ROW_IDX_W'(1);

    life_row_eval u_row_eval (
        .row_above  (grid_reg[row_up]),
        .row_centre (grid_reg[row_cnt_reg]),
        .row_below  (grid_reg[row_dn]),
        .next_row   (eval_row),
        .births     (eval_births),
        .deaths     (eval_deaths)
    );

    assign load_ready = (state_reg == IDLE);
    assign load_fire  = load_valid & load_ready;
    assign same_c     = (shadow_reg == grid_reg);
    assign tick_last  = (tick_cnt_reg == TICK_W'(TICK_DIV - 1));
    // A stop arriving in the commit cycle itself also ends the run here.
    assign halt_c     = !run_mode_reg || stop_pending_reg || cmd_stop ||
                        ((AUTO_HALT != 0) && same_c);
    assign pop_load   = population_reg - CNT_W'(popcount16(grid_reg[load_row]))
                                       + CNT_W'(popcount16(load_data));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (!cmd_clear && !load_fire && (cmd_step || cmd_run)) begin
                    state_next = COMPUTE;
                end
            end
            COMPUTE: begin
                if (row_cnt_reg == ROW_IDX_W'(GRID_H - 1)) begin
                    state_next = COMMIT;
                end
            end
            COMMIT: begin
                if (halt_c) begin
                    state_next = IDLE;
                end else if (TICK_DIV > 0) begin
                    state_next = WAIT;
                end else begin
                    state_next = COMPUTE;
                end
            end
            WAIT: begin
                if (cmd_stop) begin
                    state_next = IDLE;
                end else if (tick_last) begin
                    state_next = COMPUTE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grid_reg         <= '0;
            shadow_reg       <= '0;
            row_cnt_reg      <= '0;
            tick_cnt_reg     <= '0;
            run_mode_reg     <= 1'b0;
            stop_pending_reg <= 1'b0;
            birth_acc_reg    <= '0;
            death_acc_reg    <= '0;
            pop_acc_reg      <= '0;
            birth_cnt_reg    <= '0;
            death_cnt_reg    <= '0;
            population_reg   <= '0;
            generation_reg   <= '0;
            stable_reg       <= 1'b0;
            gen_done_reg     <= 1'b0;
        end else begin
            gen_done_reg <= (state_reg == COMMIT);
            row_cnt_reg  <= '0;
            tick_cnt_reg <= '0;
            case (state_reg)
                IDLE: begin
                    birth_acc_reg    <= '0;
                    death_acc_reg    <= '0;
                    pop_acc_reg      <= '0;
                    stop_pending_reg <= 1'b0;
                    if (cmd_clear) begin
                        grid_reg       <= '0;
                        generation_reg <= '0;
                        birth_cnt_reg  <= '0;
                        death_cnt_reg  <= '0;
                        population_reg <= '0;
                        stable_reg     <= 1'b0;
                    end else if (load_fire) begin
                        grid_reg[load_row] <= load_data;
                        population_reg     <= pop_load;
                    end else if (cmd_step) begin
                        run_mode_reg <= 1'b0;
                    end else if (cmd_run) begin
                        run_mode_reg <= 1'b1;
                    end
                end
                COMPUTE: begin
                    shadow_reg[row_cnt_reg] <= eval_row;
                    row_cnt_reg   <= row_cnt_reg + ROW_IDX_W'(1);
                    birth_acc_reg <= birth_acc_reg + CNT_W'(eval_births);
                    death_acc_reg <= death_acc_reg + CNT_W'(eval_deaths);
                    pop_acc_reg   <= pop_acc_reg + CNT_W'(popcount16(eval_row));
                    if (cmd_stop) begin
                        stop_pending_reg <= 1'b1;
                    end
                end
                COMMIT: begin
                    grid_reg       <= shadow_reg;
                    generation_reg <= generation_reg + GEN_W'(1);
                    birth_cnt_reg  <= birth_acc_reg;
                    death_cnt_reg  <= death_acc_reg;
                    population_reg <= pop_acc_reg;
                    stable_reg     <= same_c;
                    birth_acc_reg  <= '0;
                    death_acc_reg  <= '0;
                    pop_acc_reg    <= '0;
                    if (halt_c) begin
                        run_mode_reg     <= 1'b0;
                        stop_pending_reg <= 1'b0;
                    end
                end
                WAIT: begin
                    tick_cnt_reg <= tick_cnt_reg + TICK_W'(1);
                    if (cmd_stop) begin
                        run_mode_reg     <= 1'b0;
                        stop_pending_reg <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign rd_data    = grid_reg[rd_row];
    assign busy       = (state_reg != IDLE);
    assign gen_done   = gen_done_reg;
    assign generation = generation_reg;
    assign birth_cnt  = birth_cnt_reg;
    assign death_cnt  = death_cnt_reg;
    assign population = population_reg;
    assign stable     = stable_reg;

endmodule

// File: tb/tb_life_gen_controller.sv
// Self-checking bench: fixed seed table, hand-written control sequences and
// randomized seeds, all checked against a cell-by-cell Game of Life model.
`timescale 1ns/1ps
module tb_life_gen_controller;

    localparam int TICK = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load_valid = 1'b0;
    logic        load_ready;
    logic [3:0]  load_row = '0;
    logic [15:0] load_data = '0;
    logic        cmd_run = 1'b0, cmd_stop = 1'b0, cmd_step = 1'b0, cmd_clear = 1'b0;
    logic [3:0]  rd_row = '0;
    logic [15:0] rd_data;
    logic        busy, gen_done, stable;
    logic [15:0] generation;
    logic [8:0]  birth_cnt, death_cnt, population;

    always #10 clk = ~clk;

    life_gen_controller #(.GEN_W(16), .TICK_DIV(TICK), .AUTO_HALT(1)) dut (
        .clk(clk), .rst(rst),
        .load_valid(load_valid), .load_ready(load_ready),
        .load_row(load_row), .load_data(load_data),
        .cmd_run(cmd_run), .cmd_stop(cmd_stop), .cmd_step(cmd_step), .cmd_clear(cmd_clear),
        .rd_row(rd_row), .rd_data(rd_data),
        .busy(busy), .gen_done(gen_done), .generation(generation),
        .birth_cnt(birth_cnt), .death_cnt(death_cnt), .population(population),
        .stable(stable)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: plain array of rows plus statistics.
    logic [15:0] m_grid [16];
    int          m_gen, m_birth, m_death, m_pop;
    logic        m_stable;

    typedef struct {
        logic [3:0]  r0;
        logic [15:0] d0;
        logic [3:0]  r1;
        logic [15:0] d1;
        int          eb;
        int          ed;
        int          ep;
        logic        es;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int model_popcount();
        int c;
        c = 0;
        for (int r = 0; r < 16; r++)
            for (int c2 = 0; c2 < 16; c2++)
                c += int'(m_grid[r][c2]);
        return c;
    endfunction

    task automatic model_clear();
        for (int r = 0; r < 16; r++) m_grid[r] = '0;
        m_gen = 0; m_birth = 0; m_death = 0; m_pop = 0; m_stable = 1'b0;
    endtask

    task automatic model_step();
        logic [15:0] nxt [16];
        int n, b, d;
        logic alive, live_next;
        b = 0; d = 0;
        for (int r = 0; r < 16; r++) begin
            for (int c = 0; c < 16; c++) begin
                n = 0;
                for (int dr = -1; dr <= 1; dr++)
                    for (int dc = -1; dc <= 1; dc++)
                        if (dr != 0 || dc != 0)
                            n += int'(m_grid[(r + dr + 16) % 16][(c + dc + 16) % 16]);
                alive     = m_grid[r][c];
                live_next = (n == 3) || (alive && n == 2);
                nxt[r][c] = live_next;
                if (!alive && live_next) b++;
                if (alive && !live_next) d++;
            end
        end
        m_stable = 1'b1;
        for (int r = 0; r < 16; r++) if (nxt[r] != m_grid[r]) m_stable = 1'b0;
        for (int r = 0; r < 16; r++) m_grid[r] = nxt[r];
        m_gen   = (m_gen + 1) % 65536;
        m_birth = b;
        m_death = d;
        m_pop   = model_popcount();
    endtask

    // Whole-grid read-out; finishes well inside the low clock phase.
    task automatic compare_model(input string tag);
        for (int r = 0; r < 16; r++) begin
            rd_row = 4'(r);
            #0.5;
            check($sformatf("%s row%0d", tag, r), 32'(rd_data), 32'(m_grid[r]));
        end
        check({tag, " generation"}, 32'(generation), 32'(m_gen));
        check({tag, " population"}, 32'(population), 32'(m_pop));
        check({tag, " birth_cnt"},  32'(birth_cnt),  32'(m_birth));
        check({tag, " death_cnt"},  32'(death_cnt),  32'(m_death));
        check({tag, " stable"},     32'(stable),     32'(m_stable));
        $display("%s: gen=%0d pop=%0d births=%0d deaths=%0d stable=%0d",
                 tag, generation, population, birth_cnt, death_cnt, stable);
    endtask

    task automatic wait_done(input int start, output int n);
        n = start;
        while (!gen_done && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!gen_done) begin
            checks++;
            errors++;
            $display("FAIL wait_done: gen_done not seen within %0d cycles", n);
        end
    endtask

    task automatic do_load(input logic [3:0] r, input logic [15:0] d);
        load_valid = 1'b1; load_row = r; load_data = d;
        @(negedge clk);
        load_valid = 1'b0;
        m_grid[r] = d;
        m_pop = model_popcount();
    endtask

    task automatic do_clear();
        cmd_clear = 1'b1;
        @(negedge clk);
        cmd_clear = 1'b0;
        model_clear();
    endtask

    task automatic step_gen(input string tag);
        int n;
        cmd_step = 1'b1;
        @(negedge clk);
        cmd_step = 1'b0;
        wait_done(1, n);
        check({tag, " latency"}, 32'(n), 32'd18);
        model_step();
        compare_model(tag);
    endtask

    task automatic watch_quiet(input string name, input int cycles);
        int seen;
        seen = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (gen_done) seen++;
        end
        check({name, " extra gen_done"}, 32'(seen), 32'd0);
        check({name, " busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int n;

        vecs[0] = '{r0: 4'd7,  d0: 16'h0380, r1: 4'd0, d1: 16'h0000, eb: 2, ed: 2, ep: 3, es: 1'b0};
        vecs[1] = '{r0: 4'd5,  d0: 16'h8003, r1: 4'd0, d1: 16'h0000, eb: 2, ed: 2, ep: 3, es: 1'b0};
        vecs[2] = '{r0: 4'd4,  d0: 16'h0018, r1: 4'd5, d1: 16'h0018, eb: 0, ed: 0, ep: 4, es: 1'b1};
        vecs[3] = '{r0: 4'd0,  d0: 16'h0001, r1: 4'd9, d1: 16'h0000, eb: 0, ed: 1, ep: 0, es: 1'b0};
        vecs[4] = '{r0: 4'd0,  d0: 16'h0000, r1: 4'd1, d1: 16'h0000, eb: 0, ed: 0, ep: 0, es: 1'b1};
        vecs[5] = '{r0: 4'd15, d0: 16'h0380, r1: 4'd3, d1: 16'h0000, eb: 2, ed: 2, ep: 3, es: 1'b0};

        model_clear();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset load_ready", 32'(load_ready), 32'd1);
        check("reset busy",       32'(busy),       32'd0);
        check("reset gen_done",   32'(gen_done),   32'd0);
        compare_model("reset");

        // Seed table: one step each, statistics against hand-derived constants.
        for (int v = 0; v < 6; v++) begin
            do_clear();
            do_load(vecs[v].r0, vecs[v].d0);
            do_load(vecs[v].r1, vecs[v].d1);
            check($sformatf("vec%0d load population", v), 32'(population), 32'(m_pop));
            step_gen($sformatf("vec%0d", v));
            check($sformatf("vec%0d births", v), 32'(birth_cnt),  32'(vecs[v].eb));
            check($sformatf("vec%0d deaths", v), 32'(death_cnt),  32'(vecs[v].ed));
            check($sformatf("vec%0d pop", v),    32'(population), 32'(vecs[v].ep));
            check($sformatf("vec%0d stable", v), 32'(stable),     32'(vecs[v].es));
            check($sformatf("vec%0d gen", v),    32'(generation), 32'd1);
            @(negedge clk);
            check($sformatf("vec%0d pulse", v),  32'(gen_done),   32'd0);
        end

        // Still life in run mode halts after one generation.
        do_clear();
        do_load(4'd4, 16'h0018);
        do_load(4'd5, 16'h0018);
        cmd_run = 1'b1;
        @(negedge clk);
        cmd_run = 1'b0;
        wait_done(1, n);
        check("still latency", 32'(n), 32'd18);
        check("still busy at done", 32'(busy), 32'd0);
        model_step();
        compare_model("still");
        watch_quiet("still", 50);

        // Paced run of a blinker, then stop mid-COMPUTE.
        do_clear();
        do_load(4'd7, 16'h0380);
        cmd_run = 1'b1;
        @(negedge clk);
        cmd_run = 1'b0;
        wait_done(1, n);
        check("run first latency", 32'(n), 32'd18);
        model_step();
        compare_model("run g1");
        for (int g = 2; g <= 3; g++) begin
            @(negedge clk);
            check($sformatf("run g%0d pulse", g), 32'(gen_done), 32'd0);
            wait_done(1, n);
            check($sformatf("run g%0d spacing", g), 32'(n), 32'(17 + TICK));
            model_step();
            compare_model($sformatf("run g%0d", g));
        end
        repeat (8) @(negedge clk);
        check("run busy before stop", 32'(busy), 32'd1);
        cmd_stop = 1'b1;
        @(negedge clk);
        cmd_stop = 1'b0;
        wait_done(9, n);
        check("run stop spacing", 32'(n), 32'(17 + TICK));
        model_step();
        compare_model("run g4");
        watch_quiet("run stop", 60);

        // Loads and clears are ignored while busy; clear works in IDLE.
        do_clear();
        do_load(4'd7, 16'h0380);
        cmd_step = 1'b1;
        @(negedge clk);
        cmd_step = 1'b0;
        repeat (4) @(negedge clk);
        check("busy load_ready", 32'(load_ready), 32'd0);
        check("busy busy", 32'(busy), 32'd1);
        load_valid = 1'b1; load_row = 4'd3; load_data = 16'hFFFF; cmd_clear = 1'b1;
        @(negedge clk);
        load_valid = 1'b0; cmd_clear = 1'b0;
        wait_done(6, n);
        check("busy latency", 32'(n), 32'd18);
        model_step();
        compare_model("busy");
        do_clear();
        compare_model("clear");

        // Asynchronous reset at COMPUTE row 8.
        do_load(4'd7, 16'h0380);
        cmd_step = 1'b1;
        @(negedge clk);
        cmd_step = 1'b0;
        repeat (8) @(negedge clk);
        rd_row = 4'd7;
        rst = 1'b1;
        #1;
        check("arst busy",       32'(busy),       32'd0);
        check("arst generation", 32'(generation), 32'd0);
        check("arst population", 32'(population), 32'd0);
        check("arst births",     32'(birth_cnt),  32'd0);
        check("arst stable",     32'(stable),     32'd0);
        check("arst row7",       32'(rd_data),    32'd0);
        @(negedge clk);
        rst = 1'b0;
        model_clear();
        @(negedge clk);
        check("arst load_ready", 32'(load_ready), 32'd1);
        watch_quiet("arst", 30);
        do_load(4'd7, 16'h0380);
        step_gen("after reset");

        // Random seeds, several generations each.
        for (int s = 0; s < 4; s++) begin
            do_clear();
            for (int r = 0; r < 16; r++) do_load(4'(r), 16'($urandom() & $urandom()));
            check($sformatf("rand%0d load pop", s), 32'(population), 32'(m_pop));
            for (int g = 0; g < 3; g++) begin
                step_gen($sformatf("rand%0d g%0d", s, g));
                @(negedge clk);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/life_gen_controller.md
Name: life_gen_controller

Overview:
- Owns the 16x16 toroidal Game of Life grid register and sequences generation updates row-serially, one row per clock.
- Evaluation is double-buffered: a generation is computed into a shadow buffer, then committed in one cycle.
- Provides row-write seed loading, run/stop/step/clear control, tick pacing, and per-generation statistics: births, deaths, population, generation count, stable flag.
- Sits between the host/UI control logic and the display read-out.

Parameters:
- GEN_W, 16, width of the generation counter; wraps to 0 after 2^GEN_W-1.
- TICK_DIV, 0, idle cycles inserted between generations in run mode (0 = back-to-back).
- AUTO_HALT, 1, when 1, run mode returns to IDLE after a generation that leaves the grid unchanged.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- load_valid  in  1  seed row write request.
- load_ready  out  1  high only in IDLE.
- load_row  in  4  row index of the seed write.
- load_data  in  16  row contents; bit j = column j.
- cmd_run  in  1  single-cycle pulse: start continuous run.
- cmd_stop  in  1  single-cycle pulse: stop after the current generation.
- cmd_step  in  1  single-cycle pulse: compute exactly one generation.
- cmd_clear  in  1  single-cycle pulse: zero grid and statistics.
- rd_row  in  4  display read row index.
- rd_data  out  16  combinational read of the committed grid row rd_row.
- busy  out  1  high when state is not IDLE.
- gen_done  out  1  one-cycle pulse; high in the first cycle the new grid and statistics are visible.
- generation  out  GEN_W  committed generation count.
- birth_cnt  out  9  births in the last committed generation.
- death_cnt  out  9  deaths in the last committed generation.
- population  out  9  live cells in the committed grid.
- stable  out  1  last committed generation equal to its predecessor.

Behaviour:
- One clock (clk). Reset is asynchronous and active-high (rst).
- Reset, asserted at any time including mid-COMPUTE:
  - grid, shadow buffer, row counter and run_mode cleared; state IDLE.
  - generation, birth_cnt, death_cnt, population = 0; stable = 0; gen_done = 0.
  - load_ready = 1 after release; a partial generation is discarded.
- Rule, applied per cell:
  - dead with exactly 3 live neighbours -> live (birth).
  - live with 2 or 3 neighbours -> live.
  - otherwise live -> dead (death).
  - Neighbours are the 8 surrounding cells, with indices wrapping 0<->15 on both axes.
- States:
  - IDLE:
    - cmd_clear has highest priority: zero grid, generation and statistics; stable = 0.
    - Otherwise a load handshake (load_valid & load_ready) writes grid[load_row] and updates population by (new row popcount - old row popcount) on the next edge. Commands sampled in a cycle with an accepted load are ignored.
    - Otherwise cmd_step -> COMPUTE with run_mode = 0.
    - Otherwise cmd_run -> COMPUTE with run_mode = 1.
    - cmd_stop in IDLE has no effect.
  - COMPUTE:
    - Row counter r runs 0..15. Each cycle, shadow[r] = next-state of row r using committed rows r-1, r, r+1 (mod 16).
    - Births and deaths are accumulated in 9-bit accumulators.
    - After r = 15 -> COMMIT.
  - COMMIT (1 cycle):
    - grid <= shadow; generation += 1 (wrapping).
    - birth_cnt, death_cnt and population are latched; stable <= (shadow == grid).
    - gen_done is registered high for the following cycle.
    - Next state:
      - IDLE if run_mode = 0, or stop_pending, or (AUTO_HALT and stable). run_mode and stop_pending are cleared on that exit.
      - Otherwise WAIT if TICK_DIV > 0, else COMPUTE.
  - WAIT: count TICK_DIV cycles, then COMPUTE. cmd_stop here -> IDLE on the next edge.
- cmd_stop in COMPUTE or COMMIT sets stop_pending; the current generation always completes.
- Commands other than cmd_stop are ignored while busy. load_ready = 0 while busy, so loads are not accepted and the grid is unchanged.
- Latency:
  - cmd_step sampled at cycle t -> COMPUTE t+1..t+16, COMMIT t+17, gen_done high at t+18.
  - In run mode, consecutive gen_done pulses are spaced 17 + TICK_DIV cycles apart.
- rd_data always reflects the committed grid, never the shadow buffer.

Decomposition:
- Shared package (life_pkg):
  - GRID_W = 16, GRID_H = 16, ROW_IDX_W = 4, CNT_W = 9.
  - environment_t: 16 rows x 16 bits.
  - Controller state enum {IDLE, COMPUTE, COMMIT, WAIT}.
- One combinational sub-module, life_row_eval:
  - Inputs: three 16-bit rows (above, centre, below).
  - Outputs: 16-bit next row, 5-bit births, 5-bit deaths.
  - Wraps horizontally internally; the controller handles vertical wrap.

Test Plan:
1. Blinker: load row 7 = 0x0380, cmd_step
   -> gen_done 18 cycles later.
   -> rows 6,7,8 = 0x0100, other rows 0.
   -> birth_cnt = 2, death_cnt = 2, population = 3, generation = 1, stable = 0.
2. Horizontal wrap: load row 5 = 0x8003, cmd_step
   -> rows 4,5,6 = 0x0001, population = 3, births = 2, deaths = 2.
3. Still life with AUTO_HALT = 1: load rows 4,5 = 0x0018, cmd_run
   -> one gen_done, stable = 1, births = deaths = 0, busy drops, generation = 1.
4. Run pacing with TICK_DIV = 4: blinker, cmd_run
   -> gen_done every 21 cycles, grid alternates between the two blinker phases.
   -> cmd_stop mid-COMPUTE -> that generation completes, then IDLE, no further gen_done.
5. Busy rejection: load_valid (row 3 = 0xFFFF) during COMPUTE
   -> load_ready = 0, row 3 unchanged.
   -> cmd_clear in IDLE -> grid, generation and population = 0.
6. Reset at COMPUTE row 8
   -> all outputs 0 asynchronously, state IDLE.
   -> subsequent load and step behave as in scenario 1.
